clk_freq_meter: RTL and testbench
=================================

# clk_freq_meter

Measures the frequency of a slow, asynchronous signal (typically one of the divided game clocks, e.g. 2 kHz, 200 Hz, 2 Hz) by counting its rising edges over a fixed gate window timed from the board clock. Sits beside the clock-generation chain as a self-check and debug readout. Results are published as a count plus a one-cycle valid strobe.

## Interface
- `IN_FREQ`, 1e6: board clock frequency in Hz; documentation only.
- `GATE_CYCLES`, `IN_FREQ`: gate window length in `clk` cycles. Default gives a 1 s gate, so the count equals frequency in Hz. Must be ≥ 4.
- `COUNT_W`, 16: width of the result.
- `clk` in 1: board clock. One clock only.
- `rst_n` in 1: asynchronous, active-low reset.
- `sig_in` in 1: measured signal, asynchronous to `clk`.
- `run` in 1: level request to measure.
- `freq_count` out `COUNT_W`: last completed edge count. Reset 0.
- `freq_valid` out 1: one-cycle pulse when `freq_count` updates. Reset 0.
- `overflow` out 1: last completed count saturated. Reset 0.
- `busy` out 1: high while in GATE. Reset 0.

## Operation
- Input path: `sig_in` → 2-flop synchronizer → edge-detect flop. `edge = s2 & ~s3`. All three flops reset to 0.
- `run` is registered (`run_q`, reset 0). `run_rise = run & ~run_q`.
- States:
  - **IDLE**: `edge_cnt` and `gate_cnt` held at 0. On `run_rise` → GATE.
  - **GATE**:
    - `gate_cnt` counts 0..GATE_CYCLES-1.
    - `edge_cnt` increments on each `edge`, saturating at all-ones; a saturation sets a sticky `sat` flag.
    - If `run` is low, abort → IDLE. `edge_cnt`/`sat` are cleared; outputs are unchanged and no `freq_valid`.
    - On `gate_cnt == GATE_CYCLES-1`:
      - load `freq_count` with `edge_cnt` plus the edge in that cycle (saturating), and `overflow` with `sat`;
      - pulse `freq_valid`;
      - go to HOLD (single-shot) or restart GATE (see Configuration).
  - **HOLD**: wait for `run` low → IDLE. Prevents re-triggering until `run` is released.
- Width rule: `gate_cnt` is `$clog2(GATE_CYCLES)` bits. `edge_cnt` is `COUNT_W` bits and never wraps.
- Reset mid-operation returns to IDLE, clears all outputs, and discards the partial count.

## Timing
- `sig_in` rising edge to `edge` asserted: 2–3 `clk` cycles (synchronizer plus edge flop).
- `run` rising at edge N: `run_rise` is seen in cycle N. GATE occupies cycles N+1 .. N+GATE_CYCLES. `freq_valid` is high in cycle N+GATE_CYCLES+1.
- `busy` is high exactly during the GATE cycles.
- Edges counted are those whose `edge` pulse falls inside the gate window. Boundary jitter is ±1 count.
- An abort and the final gate cycle falling together: abort wins, and no `freq_valid` is produced.
- `sig_in` must have high and low phases ≥ 2 `clk` cycles. Faster signals are undercounted, with no error flag.

## Configuration
- `CLK_FREQ_METER_AUTORESTART_EN`
  - **Defined:** after each window the block goes straight back to GATE with counters cleared. There are no dead cycles, so `freq_valid` pulses every GATE_CYCLES cycles while `run` stays high. HOLD is unused. Dropping `run` aborts the window in progress.
  - **Undefined:** single-shot. Each `run` rising edge produces exactly one measurement, then the block waits in HOLD.

## Test plan
- **Basic measurement.** Setup: `GATE_CYCLES=1000`, `sig_in` period 100 `clk` with 50/50 duty and edges well away from the gate boundaries, `run` pulsed high. Required: `freq_count=10`, `freq_valid` high exactly 1 cycle, 1001 cycles after `run_rise`, `overflow=0`, `busy` high for 1000 cycles.
- **Saturation.** Setup: `COUNT_W=4`, `GATE_CYCLES=200`, `sig_in` period 4. Required: `freq_count=15`, `overflow=1`.
- **Abort.** Drop `run` at gate cycle 500 after a prior result of 10. Required: no `freq_valid`, `freq_count` stays 10, `busy` falls the next cycle, back to IDLE.
- **Reset mid-gate.** Assert `rst_n=0` mid-gate, asynchronously. Required: all outputs 0 immediately. After release, no measurement occurs until a new `run` rising edge.
- **Single-shot / auto-restart.** Hold `run` high for 3500 cycles with `GATE_CYCLES=1000`.
  - Single-shot: exactly 1 `freq_valid`.
  - With `CLK_FREQ_METER_AUTORESTART_EN`: 3 `freq_valid` pulses, spaced exactly 1000 cycles apart, each with count 10.
- **Idle quiet.** Toggle `sig_in` with `run=0` for 5000 cycles. Required: `freq_valid` never asserts, `busy=0`, `freq_count` unchanged.

Source files
------------

// File: rtl/clk_freq_meter.sv
// Gated edge counter that measures a slow asynchronous signal against the board clock.
// Define CLK_FREQ_METER_AUTORESTART_EN for back-to-back windows; default is single-shot.
module clk_freq_meter #(
  parameter int IN_FREQ     = 1_000_000,
  parameter int GATE_CYCLES = IN_FREQ,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               run,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               overflow,
  output logic               busy
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic               run_q, run_d;
  logic [GW-1:0]      gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] freq_count_q, freq_count_d;
  logic               freq_valid_q, freq_valid_d;
  logic               overflow_q, overflow_d;

  logic               edge_pulse;
  logic               run_rise;
  logic [COUNT_W-1:0] edge_next;
  logic               sat_next;

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect delay.
  assign sync_d     = {sync_q[1:0], sig_in};
  assign run_d      = run;
  assign edge_pulse = sync_q[1] & ~sync_q[2];
  assign run_rise   = run & ~run_q;

  always_comb begin
    edge_next = edge_cnt_q;
    sat_next  = sat_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_count_d = freq_count_q;
    freq_valid_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (run_rise) begin
          state_d = GATE;
        end
      end

      GATE: begin
        // Abort takes priority over completing the final gate cycle.
        if (!run) begin
          state_d    = IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          freq_count_d = edge_next;
          overflow_d   = sat_next;
          freq_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          sat_d        = 1'b0;
`ifdef CLK_FREQ_METER_AUTORESTART_EN
          state_d      = GATE;
`else
          state_d      = HOLD;
`endif
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = edge_next;
          sat_d      = sat_next;
        end
      end

      HOLD: begin
        if (!run) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      run_q        <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      run_q        <= run_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign freq_count = freq_count_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == GATE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: a 1000-cycle-gate instance for the main scenarios
// and a 4-bit, 200-cycle-gate instance for saturation.
module tb_clk_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        sig_in;
  logic        run;
  logic [15:0] freq_count;
  logic        freq_valid;
  logic        overflow;
  logic        busy;

  logic        sat_sig_in;
  logic        sat_run;
  logic [3:0]  sat_freq_count;
  logic        sat_freq_valid;
  logic        sat_overflow;
  logic        sat_busy;

  int checks = 0;
  int errors = 0;

  // Stimulus generator state and monitor accumulators, updated once per falling edge.
  int          cyc;
  bit          sig_en;
  int          sig_ph;
  int          sig_half;
  bit          sat_sig_en;
  int          sat_ph;
  int          busy_cnt;
  int          first_busy;
  int          last_busy;
  int          valid_cnt;
  int          valid_cyc [8];
  logic [15:0] valid_val [8];
  logic        valid_ovf [8];
  int          sat_valid_cnt;
  logic [3:0]  sat_val;
  logic        sat_ovf;

  clk_freq_meter #(
    .IN_FREQ    (1_000_000),
    .GATE_CYCLES(1000),
    .COUNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .run       (run),
    .freq_count(freq_count),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  clk_freq_meter #(
    .IN_FREQ    (1_000_000),
    .GATE_CYCLES(200),
    .COUNT_W    (4)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sat_sig_in),
    .run       (sat_run),
    .freq_count(sat_freq_count),
    .freq_valid(sat_freq_valid),
    .overflow  (sat_overflow),
    .busy      (sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sig_en) begin
      sig_ph++;
      if (sig_ph >= sig_half) begin
        sig_ph = 0;
        sig_in = ~sig_in;
      end
    end
    if (sat_sig_en) begin
      sat_ph++;
      if (sat_ph >= 2) begin
        sat_ph     = 0;
        sat_sig_in = ~sat_sig_in;
      end
    end
    if (busy) begin
      busy_cnt++;
      if (first_busy == 0) first_busy = cyc;
      last_busy = cyc;
    end
    if (freq_valid) begin
      if (valid_cnt < 8) begin
        valid_cyc[valid_cnt] = cyc;
        valid_val[valid_cnt] = freq_count;
        valid_ovf[valid_cnt] = overflow;
      end
      valid_cnt++;
    end
    if (sat_freq_valid) begin
      if (sat_valid_cnt == 0) begin
        sat_val = sat_freq_count;
        sat_ovf = sat_overflow;
      end
      sat_valid_cnt++;
    end
  endtask

  task automatic clear_mon();
    cyc           = 0;
    busy_cnt      = 0;
    first_busy    = 0;
    last_busy     = 0;
    valid_cnt     = 0;
    sat_valid_cnt = 0;
  endtask

  // Let any in-flight synchronizer edge drain before a window starts.
  task automatic quiesce();
    sig_en = 1'b0;
    sig_in = 1'b0;
    repeat (6) step();
  endtask

  // 100-cycle period; rising edges land on monitor cycles 50, 150, ... after this call.
  task automatic start_sig();
    sig_in   = 1'b0;
    sig_ph   = 0;
    sig_half = 50;
    sig_en   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    sig_in     = 1'b0;
    sat_run    = 1'b0;
    sat_sig_in = 1'b0;
    sig_en     = 1'b0;
    sat_sig_en = 1'b0;
    sig_half   = 50;
    clear_mon();
    repeat (3) step();
    checks++;
    if (freq_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", freq_count);
    end
    checks++;
    if (freq_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", freq_valid);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    clear_mon();
    repeat (20) step();
    checks++;
    if (valid_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL reset_quiet: got valid=%0d busy=%0d expected 0/0", valid_cnt, busy_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_mon();
    sat_ph     = 0;
    sat_sig_en = 1'b1;
    sat_run    = 1'b1;
    repeat (230) step();
    sat_run = 1'b0;
    repeat (5) step();
    sat_sig_en = 1'b0;
    checks++;
    if (sat_valid_cnt != 1) begin
      errors++;
      $display("[TB] FAIL sat_valid_count: got %0d expected 1", sat_valid_cnt);
    end
    checks++;
    if (sat_val !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_count: got %0d expected 15", sat_val);
    end
    checks++;
    if (sat_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_overflow: got %b expected 1", sat_ovf);
    end
  endtask

  task automatic test_basic();
    int exp_busy;
`ifdef CLK_FREQ_METER_AUTORESTART_EN
    exp_busy = 1010;
`else
    exp_busy = 1000;
`endif
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (1010) step();
    run = 1'b0;
    repeat (20) step();
    checks++;
    if (valid_cnt != 1) begin
      errors++;
      $display("[TB] FAIL basic_valid_count: got %0d expected 1", valid_cnt);
    end
    checks++;
    if (valid_cyc[0] != 1001) begin
      errors++;
      $display("[TB] FAIL basic_valid_cycle: got %0d expected 1001", valid_cyc[0]);
    end
    checks++;
    if (valid_val[0] !== 16'd10) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d expected 10", valid_val[0]);
    end
    checks++;
    if (valid_ovf[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_overflow: got %b expected 0", valid_ovf[0]);
    end
    checks++;
    if (first_busy != 1 || busy_cnt != exp_busy) begin
      errors++;
      $display("[TB] FAIL basic_busy: got first=%0d cycles=%0d expected first=1 cycles=%0d",
               first_busy, busy_cnt, exp_busy);
    end
    checks++;
    if (freq_count !== 16'd10) begin
      errors++;
      $display("[TB] FAIL basic_hold_count: got %0d expected 10", freq_count);
    end
  endtask

  task automatic test_abort();
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (500) step();
    run = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_busy_fall: got %b expected 0", busy);
    end
    repeat (1200) step();
    checks++;
    if (valid_cnt != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", valid_cnt);
    end
    checks++;
    if (freq_count !== 16'd10) begin
      errors++;
      $display("[TB] FAIL abort_count_kept: got %0d expected 10", freq_count);
    end
    checks++;
    if (busy_cnt != 500) begin
      errors++;
      $display("[TB] FAIL abort_busy_cycles: got %0d expected 500", busy_cnt);
    end
  endtask

  task automatic test_abort_last();
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (1000) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_last_busy: got %b expected 1", busy);
    end
    run = 1'b0;
    repeat (50) step();
    checks++;
    if (valid_cnt != 0) begin
      errors++;
      $display("[TB] FAIL abort_last_no_valid: got %0d pulses expected 0", valid_cnt);
    end
    checks++;
    if (freq_count !== 16'd10) begin
      errors++;
      $display("[TB] FAIL abort_last_count: got %0d expected 10", freq_count);
    end
  endtask

  task automatic test_reset_mid();
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (300) step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (freq_count !== 16'd0 || freq_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got count=%0d valid=%b ovf=%b busy=%b expected all 0",
               freq_count, freq_valid, overflow, busy);
    end
    run = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    clear_mon();
    repeat (1200) step();
    checks++;
    if (valid_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got valid=%0d busy=%0d expected 0/0", valid_cnt, busy_cnt);
    end
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (1010) step();
    run = 1'b0;
    repeat (10) step();
    checks++;
    if (valid_cnt != 1 || valid_val[0] !== 16'd10) begin
      errors++;
      $display("[TB] FAIL midreset_rerun: got pulses=%0d count=%0d expected 1/10",
               valid_cnt, valid_val[0]);
    end
  endtask

  task automatic test_single_shot();
    quiesce();
    clear_mon();
    start_sig();
    run = 1'b1;
    repeat (3500) step();
    run = 1'b0;
    repeat (20) step();
`ifdef CLK_FREQ_METER_AUTORESTART_EN
    checks++;
    if (valid_cnt != 3) begin
      errors++;
      $display("[TB] FAIL restart_pulses: got %0d expected 3", valid_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid_cyc[i] != 1001 + 1000 * i || valid_val[i] !== 16'd10) begin
        errors++;
        $display("[TB] FAIL restart_window%0d: got cycle=%0d count=%0d expected cycle=%0d count=10",
                 i, valid_cyc[i], valid_val[i], 1001 + 1000 * i);
      end
    end
`else
    checks++;
    if (valid_cnt != 1) begin
      errors++;
      $display("[TB] FAIL single_shot_pulses: got %0d expected 1", valid_cnt);
    end
    checks++;
    if (valid_cyc[0] != 1001 || valid_val[0] !== 16'd10) begin
      errors++;
      $display("[TB] FAIL single_shot_result: got cycle=%0d count=%0d expected 1001/10",
               valid_cyc[0], valid_val[0]);
    end
    checks++;
    if (busy_cnt != 1000) begin
      errors++;
      $display("[TB] FAIL single_shot_busy: got %0d expected 1000", busy_cnt);
    end
`endif
  endtask

  task automatic test_idle_quiet();
    quiesce();
    clear_mon();
    run      = 1'b0;
    sig_ph   = 0;
    sig_half = 5;
    sig_en   = 1'b1;
    repeat (5000) step();
    sig_en = 1'b0;
    checks++;
    if (valid_cnt != 0) begin
      errors++;
      $display("[TB] FAIL idle_valid: got %0d pulses expected 0", valid_cnt);
    end
    checks++;
    if (busy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL idle_busy: got %0d cycles expected 0", busy_cnt);
    end
    checks++;
    if (freq_count !== 16'd10) begin
      errors++;
      $display("[TB] FAIL idle_count: got %0d expected 10", freq_count);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_basic();
    test_abort();
    test_abort_last();
    test_single_shot();
    test_idle_quiet();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
